// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: registered single-cycle ops plus iterative MULTU/DIVU.
// Define ALU_DIVIDER_EN to build the restoring divider and the DIV state.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] HiResult,
  output logic             Zero
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_LUI   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
`ifdef ALU_DIVIDER_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef ALU_DIVIDER_EN
    , S_DIV = 2'd2
`endif
  } state_t;

  state_t           r_state, w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi, r_lo, r_divisor;
  logic [WIDTH-1:0] r_result, r_hires;
  logic             r_zero, r_done;

  logic [WIDTH-1:0] w_single;
  logic             w_long_op, w_single_go, w_last;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo, w_step_hi, w_step_lo;

  always_comb begin
    w_single = '0;
    case (ALUOperation)
      OP_AND:  w_single = A & B;
      OP_OR:   w_single = A | B;
      OP_NOR:  w_single = ~(A | B);
      OP_ADD:  w_single = A + B;
      OP_SUB:  w_single = A - B;
      OP_SLL:  w_single = A << shamt;
      OP_SRL:  w_single = A >> shamt;
      OP_LUI:  w_single = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: w_single = '0;
    endcase
  end

  // Shift-add: {r_hi, r_lo} starts as {0, A}; each step conditionally adds B and shifts right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_divisor} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_DIVIDER_EN
  // Restoring: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
  // B=0 naturally yields an all-ones quotient and remainder A.
  logic [WIDTH:0]   w_div_shift, w_div_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_divisor};
  assign w_div_ok    = ~w_div_diff[WIDTH];
  assign w_div_hi    = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_lo    = {r_lo[WIDTH-2:0], w_div_ok};
  assign w_step_hi   = (r_state == S_DIV) ? w_div_hi : w_mul_hi;
  assign w_step_lo   = (r_state == S_DIV) ? w_div_lo : w_mul_lo;
  assign w_long_op   = (ALUOperation == OP_MULTU) || (ALUOperation == OP_DIVU);
`else
  assign w_step_hi   = w_mul_hi;
  assign w_step_lo   = w_mul_lo;
  assign w_long_op   = (ALUOperation == OP_MULTU);
`endif

  assign w_single_go = (r_state == S_IDLE) && Start && !w_long_op;

  always_comb begin
    w_next_state = r_state;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start && ALUOperation == OP_MULTU) w_next_state = S_MUL;
`ifdef ALU_DIVIDER_EN
        else if (Start && ALUOperation == OP_DIVU) w_next_state = S_DIV;
`endif
      end
      S_MUL: begin
        if (r_count == CW'(1)) begin
          w_next_state = S_IDLE;
          w_last       = 1'b1;
        end
      end
`ifdef ALU_DIVIDER_EN
      S_DIV: begin
        if (r_count == CW'(1)) begin
          w_next_state = S_IDLE;
          w_last       = 1'b1;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_hires   <= '0;
      r_zero    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      if (w_single_go) begin
        r_result <= w_single;
        r_hires  <= '0;
        r_zero   <= (w_single == '0);
        r_done   <= 1'b1;
      end else if (r_state == S_IDLE && Start) begin
        r_hi      <= '0;
        r_lo      <= A;
        r_divisor <= B;
        r_count   <= CW'(WIDTH);
      end else if (r_state != S_IDLE) begin
        r_hi    <= w_step_hi;
        r_lo    <= w_step_lo;
        r_count <= r_count - CW'(1);
        if (w_last) begin
          r_result <= w_step_lo;
          r_hires  <= w_step_hi;
          r_zero   <= (w_step_lo == '0);
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;
  assign ALUResult = r_result;
  assign HiResult  = r_hires;
  assign Zero      = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle against an arithmetic model.
// Expectations for code 1001 follow ALU_DIVIDER_EN.
module tb_alu_multicycle;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic [3:0]    ALUOperation;
  logic [W-1:0]  A, B;
  logic [4:0]    shamt;
  logic          Busy, Done, Zero;
  logic [W-1:0]  ALUResult, HiResult;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_lo = '0;
  logic [W-1:0] prev_hi = '0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .shamt(shamt), .Busy(Busy), .Done(Done),
    .ALUResult(ALUResult), .HiResult(HiResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output int lat);
    logic [63:0] p;
    lo = '0; hi = '0; lat = 1;
    case (op)
      4'd0: lo = a & b;
      4'd1: lo = a | b;
      4'd2: lo = ~(a | b);
      4'd3: lo = a + b;
      4'd4: lo = a - b;
      4'd5: lo = a << sh;
      4'd6: lo = a >> sh;
      4'd7: lo = (b & 32'h0000FFFF) * 32'h00010000;
      4'd8: begin
        p = 64'(a) * 64'(b);
        lo = p[31:0]; hi = p[63:32]; lat = W + 1;
      end
`ifdef ALU_DIVIDER_EN
      4'd9: begin
        if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
        lat = W + 1;
      end
`endif
      default: begin lo = '0; hi = '0; end
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input bit inject);
    logic [W-1:0] elo, ehi;
    int lat, cyc, busy_cnt;
    bit seen, hold_bad;
    model(op, a, b, sh, elo, ehi, lat);
    ALUOperation = op; A = a; B = b; shamt = sh; Start = 1'b1;
    cyc = 0; busy_cnt = 0; seen = 0; hold_bad = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      Start = 1'b0;
      if (Done) seen = 1;
      else begin
        if (Busy) busy_cnt++;
        if (ALUResult !== prev_lo || HiResult !== prev_hi) hold_bad = 1;
        if (inject && cyc == 10) begin
          Start = 1'b1; ALUOperation = 4'd3; A = 32'd1; B = 32'd1;
        end
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(lat));
    check("lo", 64'(ALUResult), 64'(elo));
    check("hi", 64'(HiResult), 64'(ehi));
    check("zero", 64'(Zero), 64'(elo == 0));
    check("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    check("busy_at_done", 64'(Busy), 64'd0);
    check("hold", 64'(hold_bad), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(Done), 64'd0);
    check("held_lo", 64'(ALUResult), 64'(elo));
    prev_lo = elo; prev_hi = ehi;
  endtask

  initial begin
    int cyc, done_cnt;
    logic [3:0] rop;
    reset = 1'b1; Start = 1'b1; ALUOperation = 4'd3; A = 32'd1; B = 32'd2; shamt = '0;

    repeat (4) begin
      @(negedge clk);
      check("rst_lo", 64'(ALUResult), 64'd0);
      check("rst_hi", 64'(HiResult), 64'd0);
      check("rst_zero", 64'(Zero), 64'd1);
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
    end
    reset = 1'b0; Start = 1'b0;
    @(negedge clk);
    check("post_rst_lo", 64'(ALUResult), 64'd0);
    check("post_rst_done", 64'(Done), 64'd0);

    run_op(4'd4, 32'd5, 32'd5, 5'd0, 0);
    run_op(4'd7, 32'd0, 32'h0000ABCD, 5'd0, 0);
    run_op(4'd6, 32'h80000000, 32'd0, 5'd31, 0);
    run_op(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1);
    run_op(4'd9, 32'd100, 32'd7, 5'd0, 0);
    run_op(4'd9, 32'h1234, 32'd0, 5'd0, 0);
    run_op(4'd15, 32'h55, 32'h66, 5'd3, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (i % 4 == 0) rop = 4'd8 + 4'($urandom_range(0, 1));
      run_op(rop, $urandom, (i % 7 == 0) ? 32'd0 : $urandom, 5'($urandom_range(0, 31)), 0);
    end

    ALUOperation = 4'd8; A = $urandom; B = $urandom; Start = 1'b1;
    repeat (10) begin @(negedge clk); Start = 1'b0; end
    check("mid_busy", 64'(Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_lo", 64'(ALUResult), 64'd0);
    check("abort_hi", 64'(HiResult), 64'd0);
    check("abort_zero", 64'(Zero), 64'd1);
    check("abort_busy", 64'(Busy), 64'd0);
    done_cnt = 0;
    repeat (40) begin @(negedge clk); if (Done) done_cnt++; end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    prev_lo = '0; prev_hi = '0;
    run_op(4'd3, 32'd3, 32'd4, 5'd0, 0);

    ALUOperation = 4'd8; A = 32'd6; B = 32'd7; Start = 1'b1;
    cyc = 0;
    do begin @(negedge clk); Start = 1'b0; cyc++; end while (!Done && cyc < 100);
    check("b2b_mul_lat", 64'(cyc), 64'(W + 1));
    check("b2b_mul_lo", 64'(ALUResult), 64'd42);
    ALUOperation = 4'd3; A = 32'd10; B = 32'd20; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("b2b_add_done", 64'(Done), 64'd1);
    check("b2b_add_lo", 64'(ALUResult), 64'd30);
    check("b2b_add_hi", 64'(HiResult), 64'd0);
    check("b2b_add_busy", 64'(Busy), 64'd0);
    @(negedge clk);
    check("b2b_done_drop", 64'(Done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
